// File: rtl/mux_display_driver.sv
// -----------------------------------------------------------------------------
// mux_display_driver
//
// Multiplexed LED display driver. Scans DIGITS common-pin digits of SEG_BITS
// segments each. Every digit gets one slot of (slot_period_l + 1) clocks; the
// first BLANK_CYCLES clocks of a slot keep all digits off so the segment lines
// can settle (anti-ghosting), then the digit is lit for on_len clocks, where
// on_len scales the usable slot time by the PWM brightness. Digits flagged in
// blink_mask go dark on alternate blink half-periods. The display image is
// double-buffered: data_load writes a shadow copy, which becomes visible only
// at the next frame boundary so a frame never shows a torn image.
//
// Ports
//   clk          : clock
//   rst          : synchronous, active-high reset
//   data_in      : display image, digit 0 in the most significant SEG_BITS field
//   data_load    : one-cycle strobe, captures data_in into the shadow buffer
//   blink_mask   : bit i = 1 makes digit i blink (sampled live)
//   brightness   : 0 = off .. 2^BRIGHT_BITS-1 = max (applied per frame)
//   slot_period  : slot length minus one, in clk cycles (applied per frame)
//   seg_out      : registered segment pins
//   digit_out    : registered digit enables, one-hot while lit
//   frame_start  : one-cycle pulse on the first output cycle of digit 0
//   load_pending : shadow buffer holds data not yet displayed
// -----------------------------------------------------------------------------
module mux_display_driver #(
  parameter int DIGITS           = 4,
  parameter int SEG_BITS         = 8,
  parameter int BRIGHT_BITS      = 3,
  parameter int TIMER_BITS       = 16,
  parameter int BLANK_CYCLES     = 2,
  parameter int BLINK_FRAMES     = 32,
  parameter bit SEG_ACTIVE_LOW   = 1'b0,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIGITS*SEG_BITS-1:0] data_in,
  input  logic                       data_load,
  input  logic [DIGITS-1:0]          blink_mask,
  input  logic [BRIGHT_BITS-1:0]     brightness,
  input  logic [TIMER_BITS-1:0]      slot_period,
  output logic [SEG_BITS-1:0]        seg_out,
  output logic [DIGITS-1:0]          digit_out,
  output logic                       frame_start,
  output logic                       load_pending
);

  localparam int IDX_BITS   = $clog2(DIGITS);
  localparam int BLINK_BITS = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PROD_BITS  = TIMER_BITS + BRIGHT_BITS + 1;

  localparam logic [IDX_BITS-1:0]   LAST_IDX   = IDX_BITS'(DIGITS - 1);
  localparam logic [BLINK_BITS-1:0] LAST_BLINK = BLINK_BITS'(BLINK_FRAMES - 1);

  // Scan state
  logic [TIMER_BITS-1:0]      cnt;
  logic [IDX_BITS-1:0]        idx;
  logic [TIMER_BITS-1:0]      slot_period_l;
  logic [BRIGHT_BITS-1:0]     brightness_l;
  logic [BLINK_BITS-1:0]      blink_cnt;
  logic                       blink_phase;

  // Image buffers
  logic [DIGITS*SEG_BITS-1:0] active;
  logic [DIGITS*SEG_BITS-1:0] shadow;
  logic                       pending;

  // Combinational helpers
  logic [PROD_BITS-1:0]       period_plus1;
  logic [PROD_BITS-1:0]       avail;
  logic [PROD_BITS-1:0]       product;
  logic [PROD_BITS-1:0]       cnt_w;
  logic [PROD_BITS-1:0]       win_end;
  logic [TIMER_BITS-1:0]      on_len;
  logic                       at_slot_end;
  logic                       at_boundary;
  logic                       lit;
  logic [SEG_BITS-1:0]        seg_field;
  logic [DIGITS-1:0]          digit_next;

  assign load_pending = pending;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    period_plus1 = PROD_BITS'(slot_period_l) + PROD_BITS'(1);
    avail        = '0;
    if (period_plus1 > PROD_BITS'(BLANK_CYCLES)) begin
      avail = period_plus1 - PROD_BITS'(BLANK_CYCLES);
    end
    // avail <= 2^TIMER_BITS and brightness < 2^BRIGHT_BITS, so the product
    // fits PROD_BITS and the scaled result always fits TIMER_BITS.
    product = avail * PROD_BITS'(brightness_l);
    on_len  = TIMER_BITS'(product >> BRIGHT_BITS);

    at_slot_end = (cnt == slot_period_l);
    at_boundary = at_slot_end && (idx == LAST_IDX);

    cnt_w   = PROD_BITS'(cnt);
    win_end = PROD_BITS'(BLANK_CYCLES) + PROD_BITS'(on_len);
    lit     = (cnt_w >= PROD_BITS'(BLANK_CYCLES)) && (cnt_w < win_end)
              && !(blink_phase && blink_mask[idx]);

    // Segments follow the scanned digit for the whole slot, blank cycles
    // included, so the lines have settled before the digit switches on.
    seg_field  = active[(DIGITS - 1 - int'(idx)) * SEG_BITS +: SEG_BITS];
    digit_next = lit ? (DIGITS'(1) << idx) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      idx           <= '0;
      slot_period_l <= slot_period;
      brightness_l  <= brightness;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      // NOTE: the image buffers are plain registers, not a RAM, so they are
      // reset along with the rest of the state; reset also drops any
      // pending load.
      active        <= '0;
      shadow        <= '0;
      pending       <= 1'b0;
      seg_out       <= {SEG_BITS{SEG_ACTIVE_LOW}};
      digit_out     <= {DIGITS{DIGIT_ACTIVE_LOW}};
      frame_start   <= 1'b0;
    end else begin
      // Outputs are the registered view of the current scan state; polarity
      // is applied only here.
      seg_out     <= seg_field ^ {SEG_BITS{SEG_ACTIVE_LOW}};
      digit_out   <= digit_next ^ {DIGITS{DIGIT_ACTIVE_LOW}};
      frame_start <= (cnt == '0) && (idx == '0);

      if (at_slot_end) begin
        cnt <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_BITS'(1);
      end else begin
        cnt <= cnt + TIMER_BITS'(1);
      end

      if (at_boundary) begin
        slot_period_l <= slot_period;
        brightness_l  <= brightness;
        if (blink_cnt == LAST_BLINK) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_BITS'(1);
        end
      end

      // A load on the boundary cycle goes straight to the active image, so
      // it is shown next frame without ever raising pending.
      if (data_load && at_boundary) begin
        active  <= data_in;
        shadow  <= data_in;
        pending <= 1'b0;
      end else if (data_load) begin
        shadow  <= data_in;
        pending <= 1'b1;
      end else if (at_boundary && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux_display_driver.md
# mux_display_driver

Parametrised multiplexed LED display driver: scans `DIGITS` common-pin digits of `SEG_BITS` segments each, with PWM brightness, anti-ghosting blank time at every digit switch, per-digit blink, and a double-buffered display image updated only at frame boundaries. Sits between the system bus register block and the display pins, and is the generalised successor of the fixed 4-digit, 2-bit-brightness driver.

## Interface
- `DIGITS`, 4: number of multiplexed digits (≥2)
- `SEG_BITS`, 8: segment lines per digit (7 segments + DP)
- `BRIGHT_BITS`, 3: brightness resolution
- `TIMER_BITS`, 16: slot counter width
- `BLANK_CYCLES`, 2: forced-off cycles at the start of every slot
- `BLINK_FRAMES`, 32: frames per blink half-period
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg_out`
- `DIGIT_ACTIVE_LOW`, 0: 1 inverts `digit_out`

- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `data_in` in DIGITS*SEG_BITS: display image; digit 0 = most significant SEG_BITS field
- `data_load` in 1: one-cycle strobe, captures `data_in` into shadow buffer
- `blink_mask` in DIGITS: bit i = 1 makes digit i blink
- `brightness` in BRIGHT_BITS: 0 = off, 2^BRIGHT_BITS-1 = max
- `slot_period` in TIMER_BITS: slot length minus one, in clk cycles
- `seg_out` out SEG_BITS: segment pins (registered)
- `digit_out` out DIGITS: digit enables, one-hot when lit (registered)
- `frame_start` out 1: one-cycle pulse marking start of a frame
- `load_pending` out 1: shadow holds data not yet displayed

## Operation
- Slot counter `cnt` counts 0..`slot_period_l`, then wraps to 0 and advances digit index `idx` (0..DIGITS-1, wraps to 0). Frame = DIGITS slots.
- At frame boundary (cnt==slot_period_l, idx==DIGITS-1): latch `slot_period_l`, `brightness_l`, compute `on_len`; if `load_pending`, active ← shadow, clear pending; blink frame counter increments, toggling `blink_phase` every BLINK_FRAMES frames.
- `avail = slot_period_l + 1 - BLANK_CYCLES`, clamped to 0 if negative; `on_len = (avail * brightness_l) >> BRIGHT_BITS`, computed at TIMER_BITS+BRIGHT_BITS+1 bits, result fits TIMER_BITS.
- Lit condition: `BLANK_CYCLES ≤ cnt < BLANK_CYCLES + on_len` and not (`blink_phase` and `blink_mask[idx]`). Lit → digit bit `idx` active; else all digits inactive.
- `seg_out` = active-buffer field for `idx` in every cycle of the slot, including blank cycles (segments settle while digits are off).
- `data_load`: shadow ← `data_in`, pending ← 1. Load on the boundary cycle: active ← `data_in` directly, pending stays 0. Repeated loads before a boundary: last one wins.
- `blink_mask` is sampled live; `brightness`/`slot_period` changes take effect only at the next frame.
- Polarity parameters applied at the output register only; internal logic is active-high.

## Timing
- Reset: cnt=0, idx=0, active/shadow=0, pending=0, blink counter/phase=0, `slot_period_l`=`slot_period`, `brightness_l`=`brightness` (sampled during reset); `seg_out`, `digit_out` at inactive level (0, or all-ones when active-low); `frame_start`=0.
- All outputs lag internal state by exactly one cycle. First cycle after `rst` low has cnt=0, idx=0; next cycle `frame_start`=1 and `seg_out` shows digit 0.
- `frame_start` high for exactly one cycle per frame, coincident with first output cycle of digit 0.
- Digit lit window, in output cycles relative to slot start: cycles BLANK_CYCLES .. BLANK_CYCLES+on_len-1.
- `load_pending` rises the cycle after `data_load`, falls the cycle after the boundary.
- Reset mid-frame: same-cycle return to reset state; frame restarts at digit 0; pending data discarded.

## Test plan
- Scan: DIGITS=4, slot_period=9, brightness=7, load 0x11223344 -> after first boundary, 40-cycle frames; seg_out 0x11,0x22,0x33,0x44 for 10 cycles each; digit_out 0001/0010/0100/1000 lit cycles 2..8 of each slot; frame_start every 40 cycles.
- Brightness: slot_period=9, brightness 0/4/7 -> lit 0/4/7 cycles per slot; change from 4 to 7 mid-frame applies at next frame_start only; slot_period=1 -> never lit.
- Double buffer: load 0xAABBCCDD during digit 1 of frame N -> frame N unchanged, load_pending=1, frame N+1 shows new data, pending clears; load on boundary cycle -> shown next frame, pending never rises.
- Blink: BLINK_FRAMES=2, blink_mask=0100 -> digit 2 dark in frames 2,3,6,7, lit in 0,1,4,5; other digits unaffected; seg_out still driven.
- Polarity/reset: SEG_ACTIVE_LOW=DIGIT_ACTIVE_LOW=1 -> reset outputs all ones, lit digit 0 = 1110, segments inverted; rst mid digit 2 -> next output cycle inactive, scan restarts at digit 0 with frame_start.
